// File: rtl/pipe_pkg.sv
// Shared types and constants for the stage-3 selection collector.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } collect_state_e;

  // Lane id value meaning "lane not selected".
  localparam int unsigned N_SENTINEL = 4096;

  // Stage-2 stage code during which lane pairs are valid for capture.
  localparam logic [2:0] SELECT_STAGE = 3'd6;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] dnorm;
  } sel_entry_t;

endpackage

// File: rtl/pipe_stage3_collect_if.sv
// Valid/ready stream carrying selected (id, dnorm) pairs to write-back.
interface pipe_stage3_collect_if #(
  parameter int unsigned WIDTH = 16
);
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_id_o;
  logic [WIDTH-1:0] out_dnorm_o;

  modport master (output out_valid_o, output out_id_o, output out_dnorm_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_id_o, input out_dnorm_o, output out_ready_i);
endinterface

// File: rtl/stage3_mw_fifo.sv
// Synchronous FIFO with PARALLEL write ports and one read port.
// Write enables must be a compacted prefix (port k only if ports 0..k-1).
module stage3_mw_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned PARALLEL = 2,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PARALLEL-1:0]        wr_en_i,
  input  sel_entry_t                 wr_data_i [PARALLEL],
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output sel_entry_t                 head_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  sel_entry_t    mem_q [DEPTH];
  sel_entry_t    mem_d [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;

  assign empty_o     = (wptr_q == rptr_q);
  assign full_o      = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign occupancy_o = wptr_q - rptr_q;
  assign head_o      = mem_q[rptr_q[AW-1:0]];

  // Next storage and pointer values: consecutive slots from wptr, single pop.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    for (int unsigned k = 0; k < PARALLEL; k++) begin
      if (wr_en_i[k]) begin
        mem_d[AW'(wptr_q + (AW+1)'(k))] = wr_data_i[k];
        wptr_d = wptr_d + (AW+1)'(1);
      end
    end
    if (pop_i && !empty_o) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pipe_stage3_collect.sv
// Stage-3 collector: drops sentinel lanes, packs survivors into a FIFO,
// streams them to write-back, and tracks count/overflow/done.
module pipe_stage3_collect #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PARALLEL   = 2,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned N_SENTINEL = pipe_pkg::N_SENTINEL
) (
  input  logic                      CLK_i,
  input  logic                      RST_ni,
  input  logic                      stall_i,
  input  logic [2:0]                stage_i,
  input  logic                      finished_i,
  input  logic [PARALLEL*WIDTH-1:0] id_i,
  input  logic [PARALLEL*WIDTH-1:0] dnorm_i,
  output logic                      stall_o,
  pipe_stage3_collect_if.master     out_if,
  output logic [WIDTH-1:0]          count_o,
  output logic                      overflow_o,
  output logic                      done_o
);

  import pipe_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(PARALLEL + 1);

  collect_state_e     state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [WIDTH:0]     count_sum;

  logic [PARALLEL-1:0] wr_en;
  sel_entry_t          wr_data [PARALLEL];
  logic [CW-1:0]       n_wr;
  logic                drop;
  logic                capture;
  logic                pop;

  logic [AW:0]         occupancy;
  logic [AW:0]         free_slots;
  sel_entry_t          head;
  logic                empty;
  logic                full;

  stage3_mw_fifo #(
    .PARALLEL (PARALLEL),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk         (CLK_i),
    .rst_n       (RST_ni),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .pop_i       (pop),
    .occupancy_o (occupancy),
    .head_o      (head),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign capture    = (state_q == COLLECT) && (stage_i == SELECT_STAGE) && !stall_i;
  assign free_slots = full ? '0 : (AW+1)'(DEPTH) - occupancy;
  assign stall_o    = free_slots < (AW+1)'(PARALLEL);

  assign pop                = out_if.out_valid_o && out_if.out_ready_i;
  assign out_if.out_valid_o = !empty;
  assign out_if.out_id_o    = empty ? '0 : head.id;
  assign out_if.out_dnorm_o = empty ? '0 : head.dnorm;

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign done_o     = (state_q == DONE);

  // Lane compaction: valid lanes fill write ports in lane order while
  // start-of-cycle free space lasts; any later valid lane is dropped.
  always_comb begin
    wr_en = '0;
    n_wr  = '0;
    drop  = 1'b0;
    for (int unsigned k = 0; k < PARALLEL; k++) begin
      wr_data[k] = '0;
    end
    if (capture) begin
      for (int unsigned i = 0; i < PARALLEL; i++) begin
        if (id_i[i*WIDTH +: WIDTH] != WIDTH'(N_SENTINEL)) begin
          if ((AW+1)'(n_wr) < free_slots) begin
            wr_en[n_wr]   = 1'b1;
            wr_data[n_wr] = '{id: id_i[i*WIDTH +: WIDTH], dnorm: dnorm_i[i*WIDTH +: WIDTH]};
            n_wr          = n_wr + CW'(1);
          end else begin
            drop = 1'b1;
          end
        end
      end
    end
  end

  // Saturating write count and sticky overflow.
  always_comb begin
    count_sum  = {1'b0, count_q} + (WIDTH+1)'(n_wr);
    count_d    = count_sum[WIDTH] ? '1 : count_sum[WIDTH-1:0];
    overflow_d = overflow_q | drop;
  end

  // Next-state logic; writes only happen in COLLECT, so an empty FIFO in
  // DRAIN implies nothing is in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (finished_i)                   state_d = DRAIN;
        else if (stage_i == SELECT_STAGE) state_d = COLLECT;
      end
      COLLECT: begin
        if (finished_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage3_collect.sv
// Directed bench for pipe_stage3_collect with hand-computed expectations.
module tb_pipe_stage3_collect;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned PARALLEL = 2;
  localparam int unsigned DEPTH    = 16;
  localparam logic [15:0] S        = 16'd4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [2:0]  stage_i;
  logic        finished_i;
  logic [31:0] id_i;
  logic [31:0] dnorm_i;
  logic        stall_o;
  logic [15:0] count_o;
  logic        overflow_o;
  logic        done_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage3_collect_if #(.WIDTH(WIDTH)) out_if ();

  pipe_stage3_collect #(
    .WIDTH      (WIDTH),
    .PARALLEL   (PARALLEL),
    .DEPTH      (DEPTH),
    .N_SENTINEL (4096)
  ) dut (
    .CLK_i      (clk),
    .RST_ni     (rst_n),
    .stall_i    (stall_i),
    .stage_i    (stage_i),
    .finished_i (finished_i),
    .id_i       (id_i),
    .dnorm_i    (dnorm_i),
    .stall_o    (stall_o),
    .out_if     (out_if),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .done_o     (done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic [15:0] id0, input logic [15:0] d0,
                       input logic [15:0] id1, input logic [15:0] d1);
    id_i    = {id1, id0};
    dnorm_i = {d1, d0};
  endtask

  task automatic head_is(input string tag, input logic [15:0] id, input logic [15:0] dn);
    check_eq({tag, "_valid"}, 32'(out_if.out_valid_o), 32'd1);
    check_eq({tag, "_id"}, 32'(out_if.out_id_o), 32'(id));
    check_eq({tag, "_dnorm"}, 32'(out_if.out_dnorm_o), 32'(dn));
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    stall_i            = 1'b0;
    stage_i            = 3'd0;
    finished_i         = 1'b0;
    out_if.out_ready_i = 1'b0;
    lanes(S, 16'h0, S, 16'h0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic enter_collect();
    stage_i = 3'd6;
    lanes(S, 16'h0, S, 16'h0);
    step();
  endtask

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_valid", 32'(out_if.out_valid_o), 32'd0);
    check_eq("rst_id", 32'(out_if.out_id_o), 32'd0);
    check_eq("rst_dnorm", 32'(out_if.out_dnorm_o), 32'd0);
    check_eq("rst_count", 32'(count_o), 32'd0);
    check_eq("rst_overflow", 32'(overflow_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_stall", 32'(stall_o), 32'd0);

    // Single valid lane, one-cycle write latency
    enter_collect();
    out_if.out_ready_i = 1'b1;
    lanes(16'd7, 16'h3C00, S, 16'h4000);
    step();
    head_is("t1_head", 16'd7, 16'h3C00);
    check_eq("t1_count", 32'(count_o), 32'd1);
    lanes(S, 16'h0, S, 16'h0);
    step();
    check_eq("t1_empty_after_pop", 32'(out_if.out_valid_o), 32'd0);
    check_eq("t1_count_hold", 32'(count_o), 32'd1);

    // Fill to full, then overflow on a ninth cycle
    do_reset();
    enter_collect();
    for (int k = 0; k < 8; k++) begin
      lanes(16'd3, 16'h100 + 16'(k), 16'd5, 16'h200 + 16'(k));
      step();
      if (k == 6) check_eq("t2_stall_at14", 32'(stall_o), 32'd0);
    end
    check_eq("t2_stall_full", 32'(stall_o), 32'd1);
    check_eq("t2_count16", 32'(count_o), 32'd16);
    check_eq("t2_no_overflow", 32'(overflow_o), 32'd0);
    head_is("t2_head_stable", 16'd3, 16'h100);
    lanes(16'd3, 16'h1FF, 16'd5, 16'h2FF);
    step();
    check_eq("t2_overflow", 32'(overflow_o), 32'd1);
    check_eq("t2_count_sat16", 32'(count_o), 32'd16);
    head_is("t2_head_after_ovf", 16'd3, 16'h100);
    lanes(S, 16'h0, S, 16'h0);
    out_if.out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      head_is($sformatf("t2_drain_l0_%0d", k), 16'd3, 16'h100 + 16'(k));
      step();
      head_is($sformatf("t2_drain_l1_%0d", k), 16'd5, 16'h200 + 16'(k));
      step();
    end
    check_eq("t2_drained", 32'(out_if.out_valid_o), 32'd0);
    check_eq("t2_overflow_sticky", 32'(overflow_o), 32'd1);

    // Occupancy 15, both lanes valid: only lane 0 fits
    do_reset();
    enter_collect();
    for (int k = 0; k < 7; k++) begin
      lanes(16'h10 + 16'(2*k), 16'h0, 16'h11 + 16'(2*k), 16'h0);
      step();
    end
    lanes(16'h1E, 16'h0, S, 16'h0);
    step();
    check_eq("t3_count15", 32'(count_o), 32'd15);
    check_eq("t3_stall15", 32'(stall_o), 32'd1);
    check_eq("t3_no_overflow", 32'(overflow_o), 32'd0);
    lanes(16'h21, 16'hAAAA, 16'h22, 16'hBBBB);
    step();
    check_eq("t3_count16", 32'(count_o), 32'd16);
    check_eq("t3_overflow", 32'(overflow_o), 32'd1);
    lanes(S, 16'h0, S, 16'h0);
    out_if.out_ready_i = 1'b1;
    for (int j = 0; j < 15; j++) begin
      check_eq($sformatf("t3_order_%0d", j), 32'(out_if.out_id_o), 32'h10 + 32'(j));
      step();
    end
    head_is("t3_last", 16'h21, 16'hAAAA);
    step();
    check_eq("t3_drained", 32'(out_if.out_valid_o), 32'd0);

    // Pop plus 2-lane write at occupancy 2 across the pointer wrap
    do_reset();
    enter_collect();
    for (int k = 0; k < 7; k++) begin
      lanes(16'h40 + 16'(2*k), 16'h0, 16'h41 + 16'(2*k), 16'h0);
      step();
    end
    lanes(S, 16'h0, S, 16'h0);
    out_if.out_ready_i = 1'b1;
    for (int k = 0; k < 14; k++) step();
    check_eq("t4_empty_at14", 32'(out_if.out_valid_o), 32'd0);
    out_if.out_ready_i = 1'b0;
    lanes(16'hA, 16'h100A, 16'hB, 16'h100B);
    step();
    head_is("t4_head_a", 16'hA, 16'h100A);
    out_if.out_ready_i = 1'b1;
    lanes(16'hC, 16'h100C, 16'hD, 16'h100D);
    step();
    check_eq("t4_count18", 32'(count_o), 32'd18);
    check_eq("t4_stall_occ3", 32'(stall_o), 32'd0);
    lanes(S, 16'h0, S, 16'h0);
    head_is("t4_head_b", 16'hB, 16'h100B);
    step();
    head_is("t4_head_c", 16'hC, 16'h100C);
    step();
    head_is("t4_head_d", 16'hD, 16'h100D);
    step();
    check_eq("t4_empty_after3", 32'(out_if.out_valid_o), 32'd0);

    // finished_i with 4 queued entries: drain then done
    do_reset();
    enter_collect();
    lanes(16'd1, 16'h11, 16'd2, 16'h12);
    step();
    lanes(16'd3, 16'h13, 16'd4, 16'h14);
    step();
    lanes(S, 16'h0, S, 16'h0);
    finished_i         = 1'b1;
    out_if.out_ready_i = 1'b1;
    head_is("t5_head1", 16'd1, 16'h11);
    step();
    head_is("t5_head2", 16'd2, 16'h12);
    check_eq("t5_done_early", 32'(done_o), 32'd0);
    step();
    head_is("t5_head3", 16'd3, 16'h13);
    step();
    head_is("t5_head4", 16'd4, 16'h14);
    step();
    check_eq("t5_empty", 32'(out_if.out_valid_o), 32'd0);
    check_eq("t5_done_not_yet", 32'(done_o), 32'd0);
    step();
    check_eq("t5_done", 32'(done_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      finished_i         = k[0];
      stage_i            = 3'd6;
      out_if.out_ready_i = ~k[0];
      lanes(16'd9, 16'h9, 16'd8, 16'h8);
      step();
      check_eq($sformatf("t5_done_hold%0d", k), 32'(done_o), 32'd1);
      check_eq($sformatf("t5_count_hold%0d", k), 32'(count_o), 32'd4);
      check_eq($sformatf("t5_no_capture%0d", k), 32'(out_if.out_valid_o), 32'd0);
    end

    // finished_i with FIFO already empty
    do_reset();
    finished_i = 1'b1;
    step();
    check_eq("t5b_done_after_drain_entry", 32'(done_o), 32'd0);
    step();
    check_eq("t5b_done", 32'(done_o), 32'd1);

    // Reset mid-COLLECT with 5 entries queued
    do_reset();
    enter_collect();
    lanes(16'd1, 16'h1, 16'd2, 16'h2);
    step();
    lanes(16'd3, 16'h3, 16'd4, 16'h4);
    step();
    lanes(16'd5, 16'h5, S, 16'h0);
    step();
    check_eq("t6_count5", 32'(count_o), 32'd5);
    rst_n = 1'b0;
    lanes(16'd9, 16'h9, S, 16'h0);
    step();
    check_eq("t6_valid", 32'(out_if.out_valid_o), 32'd0);
    check_eq("t6_count", 32'(count_o), 32'd0);
    check_eq("t6_overflow", 32'(overflow_o), 32'd0);
    check_eq("t6_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("t6_idle_no_capture", 32'(count_o), 32'd0);
    check_eq("t6_idle_empty", 32'(out_if.out_valid_o), 32'd0);
    step();
    check_eq("t6_collect_capture", 32'(count_o), 32'd1);
    head_is("t6_head", 16'd9, 16'h9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
